// File: rtl/m92_pkg.sv
// Shared types and helpers for the program-ROM fetch path.
package m92_pkg;

   localparam int unsigned ROM_LINE_BYTES = 8;

   // One buffered ROM line: 8 bytes tagged by byte address bits [19:3].
   typedef struct packed {
      logic        valid;
      logic [16:0] tag;
      logic [63:0] data;
   } rom_line_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} rom_arb_state_t;

   typedef enum logic {GRANT_MAIN = 1'b0, GRANT_SND = 1'b1} rom_grant_t;

   // SDRAM byte address of a line; the sum wraps modulo 2^25 by construction.
   function automatic logic [24:0] line_addr(input logic [24:0] base, input logic [16:0] tag);
      return base + {5'b0_0000, tag, 3'b000};
   endfunction

endpackage

// File: rtl/rom_line_buffer.sv
// Single-line read buffer: hit compare, registered ready/data and lane select.
module rom_line_buffer
   import m92_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req,
   input  logic [19:0]      addr,
   input  logic             fill,
   input  logic             fill_valid,
   input  logic [16:0]      fill_tag,
   input  logic [63:0]      fill_data,
   output logic             miss,
   output logic             ready,
   output logic [WIDTH-1:0] data
);

   localparam int unsigned LANES = (ROM_LINE_BYTES * 8) / WIDTH;
   localparam int unsigned SEL_W = $clog2(LANES);

   rom_line_t        line_q;
   logic             hit;
   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] lane;

   // Hit compare and lane mux; the low address bits pick the word or byte.
   always_comb begin
      hit  = req && line_q.valid && (line_q.tag == addr[19:3]);
      miss = req && !hit;
      sel  = addr[2 -: SEL_W];
      lane = line_q.data[sel * WIDTH +: WIDTH];
   end

   // Line storage plus registered ready/data; a flush also suppresses ready at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q <= '0;
         ready  <= 1'b0;
         data   <= '0;
      end else begin
         if (fill) begin
            line_q.valid <= fill_valid;
            line_q.tag   <= fill_tag;
            line_q.data  <= fill_data;
         end else if (flush) begin
            line_q.valid <= 1'b0;
         end
         ready <= hit && !flush;
         if (hit) begin
            data <= lane;
         end
      end
   end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the SDRAM program-ROM channel between the main and sound CPU line buffers.
module rom_fetch_arbiter
   import m92_pkg::*;
#(
   parameter logic [24:0] MAIN_BASE = 25'h000000,
   parameter logic [24:0] SND_BASE  = 25'h100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        main_req,
   input  logic [19:0] main_addr,
   output logic [15:0] main_data,
   output logic        main_ready,
   input  logic        snd_req,
   input  logic [19:0] snd_addr,
   output logic [7:0]  snd_data,
   output logic        snd_ready,
   output logic [24:0] sdr_addr,
   output logic        sdr_req,
   input  logic        sdr_ack,
   input  logic [63:0] sdr_data
);

   rom_arb_state_t state_q, state_d;
   rom_grant_t     grant_q, grant_d, last_grant_q;
   logic           pend_main_q, pend_snd_q;
   logic           stale_q;
   logic [16:0]    tag_q;
   logic           main_miss, snd_miss;
   logic           ack_match, fill_done, fill_main, fill_snd, fill_valid;
   logic [16:0]    issue_tag;
   logic [24:0]    issue_base;

   // Arbiter next state, round-robin grant and fill strobes.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      fill_done = 1'b0;
      ack_match = (sdr_ack == sdr_req);
      unique case (state_q)
         IDLE: begin
            if (pend_main_q && pend_snd_q) begin
               grant_d = (last_grant_q == GRANT_MAIN) ? GRANT_SND : GRANT_MAIN;
               state_d = ISSUE;
            end else if (pend_main_q) begin
               grant_d = GRANT_MAIN;
               state_d = ISSUE;
            end else if (pend_snd_q) begin
               grant_d = GRANT_SND;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (ack_match) begin
               fill_done = 1'b1;
               state_d   = IDLE;
            end
         end
         DRAIN: begin
            if (ack_match) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      fill_main  = fill_done && (grant_q == GRANT_MAIN);
      fill_snd   = fill_done && (grant_q == GRANT_SND);
      // A flush at any point of a fetch leaves the installed line invalid.
      fill_valid = !(flush || stale_q);
      issue_tag  = (grant_q == GRANT_MAIN) ? main_addr[19:3] : snd_addr[19:3];
      issue_base = (grant_q == GRANT_MAIN) ? MAIN_BASE : SND_BASE;
   end

   // FSM, pending flags and the latched SDRAM address/tag of the current fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         // A fetch still in flight is drained so its data is never installed.
         state_q      <= (sdr_req != sdr_ack) ? DRAIN : IDLE;
         grant_q      <= GRANT_MAIN;
         last_grant_q <= GRANT_SND;
         pend_main_q  <= 1'b0;
         pend_snd_q   <= 1'b0;
         stale_q      <= 1'b0;
         tag_q        <= '0;
         sdr_addr     <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         if (state_q == ISSUE) begin
            sdr_addr     <= line_addr(issue_base, issue_tag);
            tag_q        <= issue_tag;
            last_grant_q <= grant_q;
         end
         // Fill completion and flush take priority over a new miss.
         pend_main_q <= (flush || fill_main) ? 1'b0 : (pend_main_q || main_miss);
         pend_snd_q  <= (flush || fill_snd) ? 1'b0 : (pend_snd_q || snd_miss);
         if (flush) begin
            stale_q <= 1'b0 | 1'b1;
         end else if (state_q == IDLE) begin
            stale_q <= 1'b0;
         end
      end
   end

   // Request toggle; deliberately kept across reset so an in-flight ack can be matched.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == ISSUE)) begin
         sdr_req <= !sdr_req;
      end
   end

   rom_line_buffer #(
      .WIDTH (16)
   ) u_main_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req        (main_req),
      .addr       (main_addr),
      .fill       (fill_main),
      .fill_valid (fill_valid),
      .fill_tag   (tag_q),
      .fill_data  (sdr_data),
      .miss       (main_miss),
      .ready      (main_ready),
      .data       (main_data)
   );

   rom_line_buffer #(
      .WIDTH (8)
   ) u_snd_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req        (snd_req),
      .addr       (snd_addr),
      .fill       (fill_snd),
      .fill_valid (fill_valid),
      .fill_tag   (tag_q),
      .fill_data  (sdr_data),
      .miss       (snd_miss),
      .ready      (snd_ready),
      .data       (snd_data)
   );

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter.
module tb_rom_fetch_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        main_req = 1'b0;
   logic [19:0] main_addr = '0;
   logic [15:0] main_data;
   logic        main_ready;
   logic        snd_req = 1'b0;
   logic [19:0] snd_addr = '0;
   logic [7:0]  snd_data;
   logic        snd_ready;
   logic [24:0] sdr_addr;
   logic        sdr_req;
   logic        sdr_ack = 1'b0;
   logic [63:0] sdr_data = '0;

   // Second instance used only for the base-address wrap case.
   logic        w_main_req = 1'b0;
   logic [19:0] w_main_addr = '0;
   logic [15:0] w_main_data;
   logic        w_main_ready;
   logic        w_snd_req = 1'b0;
   logic [19:0] w_snd_addr = '0;
   logic [7:0]  w_snd_data;
   logic        w_snd_ready;
   logic [24:0] w_sdr_addr;
   logic        w_sdr_req;
   logic        w_sdr_ack = 1'b0;
   logic [63:0] w_sdr_data = '0;

   int tests = 0;
   int failed = 0;
   int toggles = 0;
   logic req_prev = 1'b0;

   localparam logic [63:0] LINE_A = 64'h8877665544332211;
   localparam logic [63:0] LINE_B = 64'h0123456789ABCDEF;
   localparam logic [63:0] LINE_C = 64'hFEDCBA9876543210;
   localparam logic [63:0] LINE_LATE = 64'hDEADBEEFDEADBEEF;

   always #5 clk = ~clk;

   // Count every change of the request toggle.
   always @(negedge clk) begin
      if (sdr_req !== req_prev) toggles = toggles + 1;
      req_prev = sdr_req;
   end

   rom_fetch_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .main_req   (main_req),
      .main_addr  (main_addr),
      .main_data  (main_data),
      .main_ready (main_ready),
      .snd_req    (snd_req),
      .snd_addr   (snd_addr),
      .snd_data   (snd_data),
      .snd_ready  (snd_ready),
      .sdr_addr   (sdr_addr),
      .sdr_req    (sdr_req),
      .sdr_ack    (sdr_ack),
      .sdr_data   (sdr_data)
   );

   rom_fetch_arbiter #(
      .MAIN_BASE (25'h0000000),
      .SND_BASE  (25'h1FFFFF8)
   ) dut_wrap (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .main_req   (w_main_req),
      .main_addr  (w_main_addr),
      .main_data  (w_main_data),
      .main_ready (w_main_ready),
      .snd_req    (w_snd_req),
      .snd_addr   (w_snd_addr),
      .snd_data   (w_snd_data),
      .snd_ready  (w_snd_ready),
      .sdr_addr   (w_sdr_addr),
      .sdr_req    (w_sdr_req),
      .sdr_ack    (w_sdr_ack),
      .sdr_data   (w_sdr_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until a fetch is outstanding on the main instance.
   task automatic wait_toggle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (sdr_req !== sdr_ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic give_ack(input logic [63:0] d, input int lat);
      repeat (lat) tick();
      sdr_data = d;
      sdr_ack  = sdr_req;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      tests += 6;
      if (main_ready !== 1'b0) begin failed++; $display("FAIL reset_main_ready got %b want 0", main_ready); end
      if (snd_ready !== 1'b0) begin failed++; $display("FAIL reset_snd_ready got %b want 0", snd_ready); end
      if (main_data !== 16'h0) begin failed++; $display("FAIL reset_main_data got %h want 0", main_data); end
      if (snd_data !== 8'h0) begin failed++; $display("FAIL reset_snd_data got %h want 0", snd_data); end
      if (sdr_addr !== 25'h0) begin failed++; $display("FAIL reset_sdr_addr got %h want 0", sdr_addr); end
      if (w_sdr_addr !== 25'h0) begin failed++; $display("FAIL reset_wrap_sdr_addr got %h want 0", w_sdr_addr); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_cold_miss();
      bit ok;
      int t0;
      t0 = toggles;
      main_addr = 20'h00010;
      main_req  = 1'b1;
      wait_toggle(ok);
      tests += 3;
      if (!ok) begin failed++; $display("FAIL cold_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000010) begin failed++; $display("FAIL cold_sdr_addr got %h want 0000010", sdr_addr); end
      if (main_ready !== 1'b0) begin failed++; $display("FAIL cold_ready_early got %b want 0", main_ready); end
      give_ack(LINE_A, 4);
      tick();
      tests++;
      if (main_ready !== 1'b0) begin failed++; $display("FAIL cold_ready_at_fill got %b want 0", main_ready); end
      tick();
      tests += 2;
      if (main_ready !== 1'b1) begin failed++; $display("FAIL cold_ready got %b want 1", main_ready); end
      if (main_data !== 16'h2211) begin failed++; $display("FAIL cold_data got %h want 2211", main_data); end
      main_addr = 20'h00016;
      tick();
      tests += 2;
      if (main_ready !== 1'b1) begin failed++; $display("FAIL hit_ready got %b want 1", main_ready); end
      if (main_data !== 16'h8877) begin failed++; $display("FAIL hit_data got %h want 8877", main_data); end
      repeat (3) tick();
      tests++;
      if (toggles - t0 !== 1) begin failed++; $display("FAIL cold_toggles got %0d want 1", toggles - t0); end
      main_req = 1'b0;
      tick();
      tests++;
      if (main_ready !== 1'b0) begin failed++; $display("FAIL ready_drop got %b want 0", main_ready); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      main_addr = 20'h00000;
      snd_addr  = 20'h00100;
      main_req  = 1'b1;
      snd_req   = 1'b1;
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL tie1_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000000) begin failed++; $display("FAIL tie1_first got %h want 0000000", sdr_addr); end
      give_ack(LINE_B, 2);
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL tie1_second_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0100100) begin failed++; $display("FAIL tie1_second got %h want 0100100", sdr_addr); end
      give_ack(LINE_A, 2);
      repeat (2) tick();
      tests += 4;
      if (snd_ready !== 1'b1) begin failed++; $display("FAIL snd_ready got %b want 1", snd_ready); end
      if (snd_data !== 8'h11) begin failed++; $display("FAIL snd_byte0 got %h want 11", snd_data); end
      if (main_ready !== 1'b1) begin failed++; $display("FAIL tie_main_ready got %b want 1", main_ready); end
      if (main_data !== 16'hCDEF) begin failed++; $display("FAIL tie_main_data got %h want cdef", main_data); end
   endtask

   task automatic test_snd_lanes();
      snd_addr = 20'h00107;
      tick();
      tests += 2;
      if (snd_ready !== 1'b1) begin failed++; $display("FAIL lane7_ready got %b want 1", snd_ready); end
      if (snd_data !== 8'h88) begin failed++; $display("FAIL lane7_data got %h want 88", snd_data); end
      snd_addr = 20'h00103;
      tick();
      tests++;
      if (snd_data !== 8'h44) begin failed++; $display("FAIL lane3_data got %h want 44", snd_data); end
   endtask

   // Main alone is served first, so the following tie goes to sound.
   task automatic test_second_tie();
      bit ok;
      snd_req   = 1'b0;
      main_addr = 20'h00080;
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL solo_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000080) begin failed++; $display("FAIL solo_addr got %h want 0000080", sdr_addr); end
      give_ack(LINE_C, 1);
      repeat (2) tick();
      main_addr = 20'h000C0;
      snd_addr  = 20'h00200;
      snd_req   = 1'b1;
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL tie2_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0100200) begin failed++; $display("FAIL tie2_first got %h want 0100200", sdr_addr); end
      give_ack(LINE_A, 1);
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL tie2_second_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h00000C0) begin failed++; $display("FAIL tie2_second got %h want 00000c0", sdr_addr); end
      give_ack(LINE_C, 1);
      repeat (2) tick();
      tests += 2;
      if (main_data !== 16'h3210) begin failed++; $display("FAIL tie2_main_data got %h want 3210", main_data); end
      if (snd_data !== 8'h11) begin failed++; $display("FAIL tie2_snd_data got %h want 11", snd_data); end
   endtask

   task automatic test_flush_wait();
      bit ok;
      snd_req   = 1'b0;
      main_addr = 20'h00300;
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL flush_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000300) begin failed++; $display("FAIL flush_addr got %h want 0000300", sdr_addr); end
      give_ack(LINE_B, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tests++;
      if (main_ready !== 1'b0) begin failed++; $display("FAIL flush_ready got %b want 0", main_ready); end
      wait_toggle(ok);
      tests += 3;
      if (!ok) begin failed++; $display("FAIL flush_refetch got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000300) begin failed++; $display("FAIL flush_refetch_addr got %h want 0000300", sdr_addr); end
      if (main_ready !== 1'b0) begin failed++; $display("FAIL flush_ready_hold got %b want 0", main_ready); end
      give_ack(LINE_A, 1);
      repeat (2) tick();
      tests += 2;
      if (main_ready !== 1'b1) begin failed++; $display("FAIL flush_refill_ready got %b want 1", main_ready); end
      if (main_data !== 16'h2211) begin failed++; $display("FAIL flush_refill_data got %h want 2211", main_data); end
   endtask

   task automatic test_reset_mid_fetch();
      bit ok;
      int t0;
      main_addr = 20'h00400;
      wait_toggle(ok);
      tests++;
      if (!ok) begin failed++; $display("FAIL midrst_issue got no toggle want toggle"); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      t0 = toggles;
      repeat (3) tick();
      tests += 3;
      if (toggles !== t0) begin failed++; $display("FAIL drain_no_issue got %0d toggles want 0", toggles - t0); end
      if (main_ready !== 1'b0) begin failed++; $display("FAIL drain_ready got %b want 0", main_ready); end
      if (sdr_addr !== 25'h0) begin failed++; $display("FAIL midrst_sdr_addr got %h want 0", sdr_addr); end
      give_ack(LINE_LATE, 0);
      repeat (2) tick();
      tests++;
      if (main_ready !== 1'b0) begin failed++; $display("FAIL late_ack_ready got %b want 0", main_ready); end
      wait_toggle(ok);
      tests += 2;
      if (!ok) begin failed++; $display("FAIL post_drain_issue got no toggle want toggle"); end
      if (sdr_addr !== 25'h0000400) begin failed++; $display("FAIL post_drain_addr got %h want 0000400", sdr_addr); end
      give_ack(LINE_B, 1);
      repeat (2) tick();
      tests += 3;
      if (main_ready !== 1'b1) begin failed++; $display("FAIL post_drain_ready got %b want 1", main_ready); end
      if (main_data !== 16'hCDEF) begin failed++; $display("FAIL post_drain_data got %h want cdef", main_data); end
      if (toggles - t0 !== 1) begin failed++; $display("FAIL post_drain_toggles got %0d want 1", toggles - t0); end
      main_req = 1'b0;
      tick();
   endtask

   task automatic test_addr_wrap();
      bit ok;
      ok = 1'b0;
      w_snd_addr = 20'h00008;
      w_snd_req  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (w_sdr_req !== w_sdr_ack) begin
            ok = 1'b1;
            break;
         end
      end
      tests += 2;
      if (!ok) begin failed++; $display("FAIL wrap_issue got no toggle want toggle"); end
      if (w_sdr_addr !== 25'h0000000) begin failed++; $display("FAIL wrap_addr got %h want 0000000", w_sdr_addr); end
      tick();
      w_sdr_data = LINE_A;
      w_sdr_ack  = w_sdr_req;
      repeat (2) tick();
      tests += 2;
      if (w_snd_ready !== 1'b1) begin failed++; $display("FAIL wrap_ready got %b want 1", w_snd_ready); end
      if (w_snd_data !== 8'h11) begin failed++; $display("FAIL wrap_data got %h want 11", w_snd_data); end
      w_snd_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_simultaneous();
      test_snd_lanes();
      test_second_tie();
      test_flush_wait();
      test_reset_mid_fetch();
      test_addr_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no completion want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_fetch_arbiter.md
# rom_fetch_arbiter

Shares the single SDRAM program-ROM channel between the main V33 CPU, whose accesses are decoded by the address translator into `cpu_rom_memrq` and a 20-bit `rom_addr`, and the sound V35 CPU. Each requester gets a one-line (64-bit) read buffer. Misses are fetched over a req/ack toggle handshake. When both requesters are waiting, a round-robin arbiter picks which one is served.

## Interface
Parameters:
- `MAIN_BASE`, default 25'h000000: SDRAM byte base of the main program ROM region.
- `SND_BASE`, default 25'h100000: SDRAM byte base of the sound program ROM region.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: invalidates both line buffers. Pulsed during ROM download.
- `main_req` in 1: level. Main CPU ROM read (`cpu_rom_memrq` qualified by the bus strobe).
- `main_addr` in 20: main byte address (`rom_addr`).
- `main_data` out 16: word at `main_addr[2:1]` of the buffered line.
- `main_ready` out 1: level. `main_data` is valid.
- `snd_req` in 1: level. Sound CPU ROM read.
- `snd_addr` in 20: sound byte address.
- `snd_data` out 8: byte at `snd_addr[2:0]` of the buffered line.
- `snd_ready` out 1: level. `snd_data` is valid.
- `sdr_addr` out 25: SDRAM byte address, 8-byte aligned.
- `sdr_req` out 1: toggles once per fetch.
- `sdr_ack` in 1: set equal to `sdr_req` by the SDRAM controller when data is valid.
- `sdr_data` in 64: fetched line, little-endian. Byte 0 is bits 7:0.

## Operation
- **Line buffer (per requester):** `valid`, `tag` = addr[19:3], and 64-bit `data`.
- **Hit:** `req && valid && tag == addr[19:3]`.
- **Ready behaviour:** ready/data are registered from the hit compare each cycle.
  - Ready drops on the cycle after `req` falls or the address leaves the line.
  - The requester holds `req`/`addr` stable until it sees ready.
- **Pending flag:** set per requester on a registered miss (`req && !hit`). Cleared when that requester's fill completes.
- **FSM states:** `IDLE`, `ISSUE`, `WAIT`, `DRAIN`.
  - **IDLE:** if any pending, grant and go to `ISSUE`.
    - Only one pending: grant it.
    - Both pending: grant the one not equal to `last_grant`.
  - **ISSUE:** drive `sdr_addr` = base + {addr[19:3], 3'b000}, toggle `sdr_req`, record `last_grant`, go to `WAIT`.
  - **WAIT:** when `sdr_ack == sdr_req`, write `sdr_data` and the tag into the granted buffer, set `valid`, clear pending, go to `IDLE`.
  - **DRAIN:** wait until `sdr_ack == sdr_req`, discard the data, go to `IDLE`.
- **Tag source:** the fill tag comes from the address latched in `ISSUE`. If the requester changed address mid-fetch, the old line is installed and the new address misses again.
- **Address arithmetic:** `sdr_addr` is a 25-bit sum. Overflow wraps modulo 2^25. No range check.
- **`flush`:**
  - Clears both `valid` bits and both pending flags in the same cycle.
  - If in `WAIT`, the fill completes but `valid` stays 0.
  - Flush together with ack: flush wins.
  - Requesters re-miss afterwards.
- **Reset:**
  - Both `valid` = 0, pending = 0, `last_grant` = sound (main wins the first tie).
  - `main_ready` = `snd_ready` = 0, `main_data` = 0, `snd_data` = 0, `sdr_addr` = 0.
  - `sdr_req` is not reset (it keeps its value).
  - Next state is `DRAIN` if `sdr_req != sdr_ack`, else `IDLE`. A fetch in flight at reset is absorbed without a spurious fill.

## Timing
- **Hit:** `req` sampled high at edge t gives ready and data high after edge t+1. 1-cycle latency, then one word/byte per cycle while `addr` stays in the line.
- **Miss:**
  - t: miss registered, pending set.
  - t+1: `IDLE` grants.
  - t+2: `ISSUE` toggles `sdr_req`.
  - Edge tA, where ack matches: line written.
  - tA+1: ready high.
  - Minimum miss-to-ready is 4 cycles plus SDRAM latency.
- **Back-to-back grants:** the second requester is issued no earlier than 2 cycles after the first ack.
- **Outstanding fetches:** at most one SDRAM transaction outstanding.
- **Register stability:** `sdr_addr` is stable from `ISSUE` until ack.

## Structure
- **Shared package `m92_pkg`:**
  - `rom_line_t` packed struct: `valid`, `tag[16:0]`, `data[63:0]`.
  - `rom_arb_state_t` enum: `IDLE`/`ISSUE`/`WAIT`/`DRAIN`.
  - `ROM_LINE_BYTES` = 8.
- **Sub-module `rom_line_buffer`:** one line register, hit compare, registered ready, and the data lane mux. It has a width parameter (16 or 8). Instantiated twice.
- **Top level:** the arbiter FSM and the round-robin logic live in `rom_fetch_arbiter`.

## Test plan
- **Cold miss then hits.** Main reads 0x00010, SDRAM returns 64'h8877665544332211 after 5 cycles.
  - `sdr_addr` = 0x000010 and `main_data` = 16'h2211.
  - Changing addr to 0x00016 gives ready 1 cycle later with 16'h8877.
  - Only one `sdr_req` toggle occurs.
- **Simultaneous misses.** Main 0x00000 and sound 0x00100 miss in the same cycle after reset.
  - Main is issued first (0x000000), then sound at `SND_BASE` + 0x100 = 0x100100.
  - A second tie grants sound first.
- **Sound byte lanes.** Sound reads 0x00107 on the line above → `snd_data` = 8'h88. Reading 0x00100 → 8'h11.
- **Flush during WAIT.** Assert `flush` on the same cycle as the ack → `valid` stays 0, `main_ready` stays 0, and a new fetch is issued for the same line.
- **Reset mid-fetch.** Assert `reset` while `sdr_req != sdr_ack`.
  - FSM enters `DRAIN`, no ready asserts, and the late ack is discarded.
  - The next miss toggles `sdr_req` normally.
- **Address wrap.** With `SND_BASE` = 25'h1FFFFF8 and addr 0x00008, `sdr_addr` = 25'h0000000.
